// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed framer with configurable word length,
// parity and stop bits. Frames are sent back-to-back while words are queued.
module uart_tx_buffered #(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                               clk_glb,
  input  logic                               rst_n,
  input  logic                               s_valid,
  input  logic [WORD_LENGTH-1:0]             s_data,
  output logic                               s_ready,
  output logic                               tx_out,
  output logic                               tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int unsigned DIVISOR = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BIT_W   = 4;

  if (WORD_LENGTH < 5 || WORD_LENGTH > 9 || PARITY_MODE > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || DIVISOR < 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_buffered: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [WORD_LENGTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [LVL_W-1:0]       level;
  logic                   push;
  logic                   pop;
  logic                   fifo_empty;
  logic [WORD_LENGTH-1:0] head;

  state_t                 state, state_next;
  logic [WORD_LENGTH-1:0] shreg, shreg_next;
  logic [CNT_W-1:0]       baud_cnt, baud_next;
  logic [BIT_W-1:0]       bit_cnt, bit_next;
  logic                   par_bit, par_next;
  logic                   tx_q, tx_next;
  logic                   busy_q;
  logic                   bit_end;
  logic                   start_frame;

  assign s_ready    = (level != LVL_W'(FIFO_DEPTH));
  assign push       = s_valid && s_ready;
  assign fifo_empty = (level == '0);
  assign head       = mem[rd_ptr];
  assign fifo_level = level;
  assign tx_out     = tx_q;
  assign tx_busy    = busy_q;

  always_ff @(posedge clk_glb) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk_glb or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: ;
      endcase
    end
  end

  assign bit_end = (baud_cnt == CNT_W'(DIVISOR - 1));

  always_comb begin
    state_next  = state;
    shreg_next  = shreg;
    baud_next   = baud_cnt;
    bit_next    = bit_cnt;
    par_next    = par_bit;
    tx_next     = tx_q;
    start_frame = 1'b0;
    pop         = 1'b0;

    if (state != IDLE) begin
      baud_next = bit_end ? '0 : baud_cnt + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) start_frame = 1'b1;
      end
      START: begin
        if (bit_end) begin
          tx_next    = shreg[0];
          shreg_next = shreg >> 1;
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == BIT_W'(WORD_LENGTH - 1)) begin
            bit_next = '0;
            if (PARITY_MODE != 0) begin
              tx_next    = par_bit;
              state_next = PARITY;
            end else begin
              tx_next    = 1'b1;
              state_next = STOP;
            end
          end else begin
            tx_next    = shreg[0];
            shreg_next = shreg >> 1;
            bit_next   = bit_cnt + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_next    = 1'b1;
          bit_next   = '0;
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            bit_next = '0;
            if (!fifo_empty) begin
              start_frame = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_next = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase

    // Frame launch is shared by IDLE and the end of STOP so back-to-back
    // frames start with the same timing as a frame from idle.
    if (start_frame) begin
      pop        = 1'b1;
      shreg_next = head;
      par_next   = (^head) ^ (PARITY_MODE == 2);
      tx_next    = 1'b0;
      baud_next  = '0;
      bit_next   = '0;
      state_next = START;
    end
  end

  always_ff @(posedge clk_glb or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      par_bit  <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_next;
      shreg    <= shreg_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      par_bit  <= par_next;
      tx_q     <= tx_next;
      busy_q   <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench: three transmitter configurations; a frame-level line
// monitor checks every clock of every frame against words queued by stimulus.
module tb_uart_tx_buffered;

  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int DIV      = 16;
  localparam int DEPTH    = 4;
  localparam int N        = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid    [N];
  logic [8:0] s_data     [N];
  logic       s_ready    [N];
  logic       tx_out     [N];
  logic       tx_busy    [N];
  logic [2:0] fifo_level [N];

  int cyc = 0;
  int total = 0;
  int bad = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];

  int          mon_pos  [N];
  logic [15:0] mon_bits [N];
  int          mon_nb   [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance 0: 8N1, instance 1: 7 bits even parity 2 stop, instance 2: 7 bits odd parity 1 stop
  function automatic int wl(input int i);
    return (i == 0) ? 8 : 7;
  endfunction
  function automatic int pm(input int i);
    return i;
  endfunction
  function automatic int sb(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = (g == 0) ? 8 : 7;
    localparam int P = g;
    localparam int S = (g == 1) ? 2 : 1;
    uart_tx_buffered #(
      .WORD_LENGTH(W),
      .PARITY_MODE(P),
      .STOP_BITS(S),
      .CLK_FREQ(CLK_FREQ),
      .BAUD_RATE(BAUD),
      .FIFO_DEPTH(DEPTH)
    ) u_dut (
      .clk_glb(clk),
      .rst_n(rst_n),
      .s_valid(s_valid[g]),
      .s_data(s_data[g][W-1:0]),
      .s_ready(s_ready[g]),
      .tx_out(tx_out[g]),
      .tx_busy(tx_busy[g]),
      .fifo_level(fifo_level[g])
    );
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic q_push(input int i, input logic [8:0] d);
    case (i)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic q_pop(input int i, output logic [8:0] d);
    case (i)
      0:       d = q0.pop_front();
      1:       d = q1.pop_front();
      default: d = q2.pop_front();
    endcase
  endtask

  task automatic q_clear();
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  // Expected line levels of one frame, one entry per bit, LSB first.
  task automatic build(input int i, input logic [8:0] d, output logic [15:0] bits, output int n);
    int ones;
    ones = 0;
    bits = '1;
    bits[0] = 1'b0;
    for (int k = 0; k < wl(i); k++) begin
      bits[1 + k] = d[k];
      ones += int'(d[k]);
    end
    n = 1 + wl(i);
    if (pm(i) != 0) begin
      bits[n] = ((ones % 2) == 1) ^ (pm(i) == 2);
      n++;
    end
    n += sb(i);
  endtask

  initial begin : monitor
    logic [8:0] w;
    int b;
    for (int i = 0; i < N; i++) mon_pos[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!rst_n) begin
          mon_pos[i] = 0;
        end else if (mon_pos[i] == 0) begin
          if (tx_out[i] == 1'b0) begin
            check($sformatf("frame_expected[%0d]", i), int'(q_size(i) != 0), 1);
            if (q_size(i) != 0) begin
              q_pop(i, w);
              build(i, w, mon_bits[i], mon_nb[i]);
              mon_pos[i] = 1;
              check($sformatf("start_busy[%0d]", i), int'(tx_busy[i]), 1);
            end
          end else begin
            check($sformatf("idle_busy[%0d]", i), int'(tx_busy[i]), 0);
          end
        end else begin
          mon_pos[i]++;
          b = (mon_pos[i] - 1) / DIV;
          check($sformatf("line_bit%0d[%0d]", b, i), int'(tx_out[i]), int'(mon_bits[i][b]));
          check($sformatf("frame_busy[%0d]", i), int'(tx_busy[i]), 1);
          if (mon_pos[i] == mon_nb[i] * DIV) mon_pos[i] = 0;
        end
      end
    end
  end

  // Leaves s_valid asserted; returns at the negedge after the accepting edge.
  task automatic send(input int i, input logic [8:0] d);
    logic [8:0] m;
    int n;
    m = '1;
    m = m >> (9 - wl(i));
    s_valid[i] = 1'b1;
    s_data[i] = d;
    n = 0;
    while (!s_ready[i] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready[i]) begin
      check($sformatf("ready_timeout[%0d]", i), int'(s_ready[i]), 1);
      s_valid[i] = 1'b0;
    end else begin
      @(posedge clk);
      q_push(i, s_data[i] & m);
      @(negedge clk);
    end
  endtask

  task automatic release_valid(input int i);
    s_valid[i] = 1'b0;
  endtask

  task automatic watch(input int i, input int nbits, input logic [15:0] pat);
    for (int t = 1; t <= nbits * DIV + 1; t++) begin
      @(negedge clk);
      if (t == 1) check($sformatf("start_latency[%0d]", i), int'(tx_out[i]), 0);
      if (t <= nbits * DIV && ((t - 1) % DIV) == DIV / 2)
        check($sformatf("pattern_bit%0d[%0d]", (t - 1) / DIV, i), int'(tx_out[i]), int'(pat[(t - 1) / DIV]));
      if (t == nbits * DIV) check($sformatf("busy_last[%0d]", i), int'(tx_busy[i]), 1);
      if (t == nbits * DIV + 1) check($sformatf("busy_drop[%0d]", i), int'(tx_busy[i]), 0);
    end
  endtask

  task automatic drain();
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 6000) begin
      @(negedge clk);
      n++;
      done = 1'b1;
      for (int i = 0; i < N; i++)
        if (q_size(i) != 0 || mon_pos[i] != 0 || tx_busy[i]) done = 1'b0;
    end
    check("drain_complete", int'(done), 1);
  endtask

  initial begin : stimulus
    int c1;
    int c6;
    int gap;
    for (int i = 0; i < N; i++) begin
      s_valid[i] = 1'b0;
      s_data[i] = '0;
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_tx[%0d]", i), int'(tx_out[i]), 1);
      check($sformatf("rst_busy[%0d]", i), int'(tx_busy[i]), 0);
      check($sformatf("rst_ready[%0d]", i), int'(s_ready[i]), 1);
      check($sformatf("rst_level[%0d]", i), int'(fifo_level[i]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    send(0, 9'h0A5);
    release_valid(0);
    watch(0, 10, 16'h034A);

    send(2, 9'h013);
    release_valid(2);
    watch(2, 10, 16'h0226);
    send(1, 9'h013);
    release_valid(1);
    watch(1, 11, 16'h0726);

    send(1, 9'h000);
    send(1, 9'h07F);
    release_valid(1);
    check("b2b_level", int'(fifo_level[1]), 1);
    check("b2b_first_start", int'(tx_out[1]), 0);
    repeat (175) @(negedge clk);
    check("b2b_stop_tail", int'(tx_out[1]), 1);
    check("b2b_busy_held", int'(tx_busy[1]), 1);
    @(negedge clk);
    check("b2b_second_start", int'(tx_out[1]), 0);
    drain();

    send(0, 9'($urandom));
    c1 = cyc;
    for (int k = 0; k < 4; k++) send(0, 9'($urandom));
    check("full_ready", int'(s_ready[0]), 0);
    check("full_level", int'(fifo_level[0]), 4);
    send(0, 9'($urandom));
    c6 = cyc;
    release_valid(0);
    // the 6th slot frees when frame 2 pops at c1+161; accept is the edge after
    check("sixth_accept_delay", c6 - c1, 162);
    drain();

    send(0, 9'($urandom));
    send(0, 9'($urandom));
    release_valid(0);
    repeat (159) @(negedge clk);
    send(0, 9'($urandom));
    release_valid(0);
    check("pushpop_level", int'(fifo_level[0]), 1);
    check("pushpop_restart", int'(tx_out[0]), 0);
    drain();

    send(0, 9'h000);
    send(0, 9'h0FF);
    send(0, 9'h03C);
    release_valid(0);
    repeat (40) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tx", int'(tx_out[0]), 1);
    check("midrst_busy", int'(tx_busy[0]), 0);
    check("midrst_level", int'(fifo_level[0]), 0);
    check("midrst_ready", int'(s_ready[0]), 1);
    q_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("postrst_level", int'(fifo_level[0]), 0);
    check("postrst_tx", int'(tx_out[0]), 1);

    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 12; k++) begin
        send(i, 9'($urandom));
        gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
        if (gap > 0) begin
          release_valid(i);
          repeat (gap) @(negedge clk);
        end
      end
      release_valid(i);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
